// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch, load/store and SRAM port signals of the memory arbiter.
// slave is the arbiter's view; master is the view of the surrounding core/SRAM.
interface mem_arb_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  // Fetch path
  logic          f_req_i;
  logic [AW-1:0] f_addr_i;
  logic          flush_i;
  logic          hold_o;
  logic          instr_valid_o;
  logic [DW-1:0] instr_o;

  // Load/store path
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [SW-1:0] d_wstrb_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [DW-1:0] d_rdata_o;

  // SRAM port
  logic          sram_ce_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [SW-1:0] sram_wstrb_o;
  logic [DW-1:0] sram_rdata_i;

  modport slave (
    input  f_req_i, f_addr_i, flush_i,
    output hold_o, instr_valid_o, instr_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output sram_ce_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wstrb_o,
    input  sram_rdata_i
  );

  modport master (
    output f_req_i, f_addr_i, flush_i,
    input  hold_o, instr_valid_o, instr_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  sram_ce_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wstrb_o,
    output sram_rdata_i
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: single-port SRAM arbiter, data accesses over instruction fetch.
// Define ARB_STARVE_GUARD_EN to force a fetch slot after MAX_DATA_BURST data grants.
module mem_arb #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_arb_if.slave   bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DREAD = 2'd2
  } own_e;

  own_e own_q;
  own_e own_d;
  logic kill_q;
  logic force_f_c;
  logic gnt_d_c;
  logic gnt_f_c;
  logic wr_c;

  // Grants are held off during reset so the SRAM port stays quiet.
  assign gnt_d_c = rst_n & bus.d_req_i & ~force_f_c;
  assign gnt_f_c = rst_n & bus.f_req_i & ~gnt_d_c;
  assign wr_c    = gnt_d_c & bus.d_we_i;

`ifdef ARB_STARVE_GUARD_EN
  logic [CW-1:0] cnt_q;

  // Counts data grants won while fetch waits; hitting the limit yields one fetch slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (gnt_f_c || !bus.f_req_i) begin
      cnt_q <= '0;
    end else if (gnt_d_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign force_f_c = bus.f_req_i & (cnt_q == CW'(MAX_DATA_BURST));
`else
  logic unused_burst;
  assign unused_burst = ^CW'(MAX_DATA_BURST);
  assign force_f_c    = 1'b0;
`endif

  // SRAM port: address from the winner, write payload only on store cycles.
  always_comb begin
    bus.sram_ce_o    = gnt_d_c | gnt_f_c;
    bus.sram_we_o    = wr_c;
    bus.sram_addr_o  = AW'(0);
    bus.sram_wdata_o = DW'(0);
    bus.sram_wstrb_o = SW'(0);
    if (gnt_d_c) begin
      bus.sram_addr_o = bus.d_addr_i;
    end else if (gnt_f_c) begin
      bus.sram_addr_o = bus.f_addr_i;
    end
    if (wr_c) begin
      bus.sram_wdata_o = bus.d_wdata_i;
      bus.sram_wstrb_o = bus.d_wstrb_i;
    end
  end

  assign bus.d_gnt_o = gnt_d_c;
  assign bus.hold_o  = bus.f_req_i & ~gnt_f_c;

  // Response owner: who the SRAM read data belongs to next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  always_comb begin
    own_d = OWN_NONE;
    if (gnt_f_c) begin
      own_d = OWN_FETCH;
    end else if (gnt_d_c && !bus.d_we_i) begin
      own_d = OWN_DREAD;
    end
  end

  // A sampled flush drops whatever fetch word comes back on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
    end else begin
      kill_q <= bus.flush_i;
    end
  end

  assign bus.instr_valid_o = (own_q == OWN_FETCH) & ~kill_q;
  assign bus.instr_o       = bus.instr_valid_o ? bus.sram_rdata_i : DW'(0);
  assign bus.d_rvalid_o    = (own_q == OWN_DREAD);
  assign bus.d_rdata_o     = bus.d_rvalid_o ? bus.sram_rdata_i : DW'(0);

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed plus random stimulus for mem_arb, checked against a
// transaction-level model of grants, SRAM contents and one-cycle responses.
module tb_mem_arb;
  localparam int unsigned BURST = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_FETCH = 2'd1;
  localparam logic [1:0] K_DREAD = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arb_if bus ();

  mem_arb #(.MAX_DATA_BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Behavioural SRAM: unwritten words read as address + 0x100; garbage on idle cycles.
  logic [31:0] sram_mem [logic [31:0]];
  always @(posedge clk) begin : sram_model
    logic [31:0] w;
    if (bus.sram_ce_o && !bus.sram_we_o) begin
      bus.sram_rdata_i <= sram_mem.exists(bus.sram_addr_o) ? sram_mem[bus.sram_addr_o]
                                                           : bus.sram_addr_o + 32'h100;
    end else begin
      bus.sram_rdata_i <= $urandom;
    end
    if (bus.sram_ce_o && bus.sram_we_o) begin
      w = sram_mem.exists(bus.sram_addr_o) ? sram_mem[bus.sram_addr_o]
                                           : bus.sram_addr_o + 32'h100;
      for (int b = 0; b < 4; b++)
        if (bus.sram_wstrb_o[b]) w[8*b +: 8] = bus.sram_wdata_o[8*b +: 8];
      sram_mem[bus.sram_addr_o] = w;
    end
  end

  // Reference model state
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic        dead;
  } resp_t;

  resp_t       inflight;
  int          run_len;
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a + 32'h100;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk32(tag, 32'(obs), 32'(exp));
  endtask

  task automatic drive(input bit fr, input logic [31:0] fa, input bit fl, input bit dr,
                       input bit dw, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [3:0] ds);
    bus.f_req_i   = fr;
    bus.f_addr_i  = fa;
    bus.flush_i   = fl;
    bus.d_req_i   = dr;
    bus.d_we_i    = dw;
    bus.d_addr_i  = da;
    bus.d_wdata_i = dwd;
    bus.d_wstrb_i = ds;
  endtask

  // One clock cycle: apply inputs, check response and grant outputs, advance model.
  task automatic step(input bit fr, input logic [31:0] fa, input bit fl, input bit dr,
                      input bit dw, input logic [31:0] da, input logic [31:0] dwd,
                      input logic [3:0] ds);
    bit          egd, egf;
    logic        exp_iv, exp_dv;
    logic [31:0] exp_addr, w;
    resp_t       nxt;
    @(negedge clk);
    drive(fr, fa, fl, dr, dw, da, dwd, ds);
    #1;
    exp_iv = (inflight.kind == K_FETCH) && !inflight.dead;
    exp_dv = (inflight.kind == K_DREAD);
    chk1 ("instr_valid", bus.instr_valid_o, exp_iv);
    chk32("instr",       bus.instr_o,       exp_iv ? inflight.data : 32'h0);
    chk1 ("d_rvalid",    bus.d_rvalid_o,    exp_dv);
    chk32("d_rdata",     bus.d_rdata_o,     exp_dv ? inflight.data : 32'h0);

    egd = dr && !(GUARD && fr && run_len == int'(BURST));
    egf = fr && !egd;
    exp_addr = egd ? da : (egf ? fa : 32'h0);
    chk1 ("d_gnt",      bus.d_gnt_o,      egd);
    chk1 ("hold",       bus.hold_o,       fr && !egf);
    chk1 ("sram_ce",    bus.sram_ce_o,    egd || egf);
    chk1 ("sram_we",    bus.sram_we_o,    egd && dw);
    chk32("sram_addr",  bus.sram_addr_o,  exp_addr);
    chk32("sram_wdata", bus.sram_wdata_o, (egd && dw) ? dwd : 32'h0);
    chk32("sram_wstrb", bus.sram_wstrb_o, (egd && dw) ? 32'(ds) : 32'h0);

    nxt.kind = egf ? K_FETCH : ((egd && !dw) ? K_DREAD : K_NONE);
    nxt.data = ref_rd(exp_addr);
    nxt.dead = fl;
    if (egd && dw) begin
      w = ref_rd(da);
      for (int b = 0; b < 4; b++) if (ds[b]) w[8*b +: 8] = dwd[8*b +: 8];
      ref_mem[da] = w;
    end
    if (egf || !fr) run_len = 0;
    else if (egd) run_len++;
    inflight = nxt;
  endtask

  task automatic idle();
    step(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk1 ({tag, "_instr_valid"}, bus.instr_valid_o, 1'b0);
    chk32({tag, "_instr"},       bus.instr_o,       32'h0);
    chk1 ({tag, "_d_rvalid"},    bus.d_rvalid_o,    1'b0);
    chk32({tag, "_d_rdata"},     bus.d_rdata_o,     32'h0);
    chk1 ({tag, "_d_gnt"},       bus.d_gnt_o,       1'b0);
    chk1 ({tag, "_hold"},        bus.hold_o,        1'b0);
    chk1 ({tag, "_sram_ce"},     bus.sram_ce_o,     1'b0);
    chk1 ({tag, "_sram_we"},     bus.sram_we_o,     1'b0);
    chk32({tag, "_sram_addr"},   bus.sram_addr_o,   32'h0);
    chk32({tag, "_sram_wdata"},  bus.sram_wdata_o,  32'h0);
    chk32({tag, "_sram_wstrb"},  bus.sram_wstrb_o,  32'h0);
  endtask

  initial begin : stimulus
    logic [9:0]  gnt_seen;
    logic [9:0]  gnt_exp;
    logic [31:0] ra;
    inflight = '0;
    run_len  = 0;
    rst_n    = 1'b0;
    bus.sram_rdata_i = 32'h0;
    drive(0, 32'h0, 0, 1, 1, 32'h44, 32'h1234_5678, 4'hF);
    #12;
    check_all_zero("por");
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b1;
    #1;
    check_all_zero("post_rst");

    // Fetch only: instructions 0x100, 0x104, 0x108 on the following cycles
    step(1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    step(1, 32'h4, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    chk32("fetch0_word", bus.instr_o, 32'h100);
    step(1, 32'h8, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    chk32("fetch1_word", bus.instr_o, 32'h104);
    idle();
    chk32("fetch2_word", bus.instr_o, 32'h108);

    // Load collision: data wins, fetch held
    step(1, 32'hC, 0, 1, 0, 32'h40, 32'h0, 4'h0);
    chk1("collide_hold", bus.hold_o, 1'b1);
    step(1, 32'hC, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    chk32("collide_load", bus.d_rdata_o, 32'h140);

    // Store of two low bytes, then read back the merged word
    step(0, 32'h0, 0, 1, 1, 32'h80, 32'hDEAD_BEEF, 4'h3);
    step(0, 32'h0, 0, 1, 0, 32'h80, 32'h0, 4'h0);
    idle();
    chk32("store_merge", bus.d_rdata_o, 32'h0000_BEEF);

    // Flush with a fetch grant: that response dies, the next one survives
    step(1, 32'h10, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    step(1, 32'h14, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    chk1("flush_killed", bus.instr_valid_o, 1'b0);
    idle();
    chk32("flush_next", bus.instr_o, 32'h114);

    // Flush with no fetch outstanding must not disturb a load response
    step(0, 32'h0, 1, 1, 0, 32'h48, 32'h0, 4'h0);
    idle();

    // Ten cycles of both requesting
    idle();
    gnt_seen = '0;
    gnt_exp  = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(i) << 2, 0, 1, 0, 32'h100 + (32'(i) << 2), 32'h0, 4'h0);
      gnt_seen[i] = bus.d_gnt_o;
      gnt_exp[i]  = GUARD ? ((i % (int'(BURST) + 1)) != int'(BURST)) : 1'b1;
    end
    chk32("starve_pattern", 32'(gnt_seen), 32'(gnt_exp));
    idle();

    // Reset one cycle after a load grant drops the response at once
    step(0, 32'h0, 0, 1, 0, 32'h4C, 32'h0, 4'h0);
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 1, 32'h88, 32'hFFFF_FFFF, 4'hF);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b1;
    inflight = '0;
    run_len  = 0;
    #1;
    check_all_zero("rst_release");
    idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ra = 32'($urandom_range(0, 15)) << 2;
      step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 15)) << 2,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0, ra, $urandom, 4'($urandom_range(0, 15)));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
